// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot stage that sits in front of the pipelined CPU. After reset it zero-fills
// the whole instruction memory, then consumes a little-endian byte stream:
//     header word N, N instruction words, one data word.
// The instruction words go to instruction memory at word index 0..N-1, the data
// word goes to data memory byte address 0x00, and finally the CPU start line is
// raised and held until the next reset. A header of 0 or larger than the
// instruction memory parks the loader in an error state with no further writes.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous active-low reset
//   byte_i          stream byte
//   valid_i         byte_i valid
//   ready_o         loader accepts a byte this cycle (registered)
//   imem_we_o       instruction-memory write strobe
//   imem_addr_o     instruction word index
//   imem_data_o     instruction word
//   dmem_we_o       data-memory write strobe
//   dmem_addr_o     data-memory byte address (always 0x00)
//   dmem_data_o     data word
//   start_o         CPU start
//   busy_o          high while clearing or loading
//   err_o           bad header seen
//   words_loaded_o  instruction words written so far
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              dmem_we_o,
    output logic [31:0]       dmem_addr_o,
    output logic [31:0]       dmem_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_DATA  = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] C_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] C_DEPTH   = IMEM_DEPTH[ADDR_W:0];
    localparam logic [31:0]     C_DEPTH32 = 32'(IMEM_DEPTH);

    // FSM state
    state_t             r_state;
    state_t             w_next_state;

    // Datapath registers
    logic [ADDR_W:0]    r_clr_cnt;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_asm;
    logic [ADDR_W:0]    r_n;
    logic [ADDR_W:0]    r_idx;

    // Registered outputs
    logic               r_ready;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_data;
    logic               r_dmem_we;
    logic [31:0]        r_dmem_data;
    logic               r_start;
    logic               r_busy;
    logic               r_err;
    logic [ADDR_W:0]    r_words;

    // Next values for the registers above
    logic [ADDR_W:0]    w_clr_cnt;
    logic [ADDR_W:0]    w_n;
    logic [ADDR_W:0]    w_idx;
    logic               w_ready;
    logic               w_imem_we;
    logic [ADDR_W-1:0]  w_imem_addr;
    logic [31:0]        w_imem_data;
    logic               w_dmem_we;
    logic [31:0]        w_dmem_data;
    logic               w_start;
    logic               w_busy;
    logic               w_err;
    logic [ADDR_W:0]    w_words;

    // Stream decode
    logic               w_accept;
    logic               w_word_done;
    logic [31:0]        w_word;
    logic               w_hdr_bad;
    logic [ADDR_W:0]    w_idx_inc;

    // ready_o is registered, so acceptance only depends on flops and valid_i.
    assign w_accept    = valid_i & r_ready;
    assign w_word_done = w_accept & (r_byte_cnt == 2'd3);
    // The 4th byte is still on byte_i; the first three sit in r_asm.
    assign w_word      = {byte_i, r_asm};
    assign w_hdr_bad   = (w_word == 32'd0) || (w_word > C_DEPTH32);
    assign w_idx_inc   = r_idx + C_ONE;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == C_DEPTH) begin
                    w_next_state = S_HDR;
                end else begin
                    w_next_state = S_CLEAR;
                end
            end
            S_HDR: begin
                if (w_word_done) begin
                    if (w_hdr_bad) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end else begin
                    w_next_state = S_HDR;
                end
            end
            S_LOAD: begin
                if (w_word_done && (w_idx_inc == r_n)) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_DATA: begin
                if (w_word_done) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_RUN:   w_next_state = S_RUN;
            S_ERR:   w_next_state = S_ERR;
            // An illegal encoding parks the loader where it cannot write memory.
            default: w_next_state = S_ERR;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        w_clr_cnt   = r_clr_cnt;
        w_n         = r_n;
        w_idx       = r_idx;
        w_words     = r_words;
        w_imem_we   = 1'b0;
        w_imem_addr = r_imem_addr;
        w_imem_data = r_imem_data;
        w_dmem_we   = 1'b0;
        w_dmem_data = r_dmem_data;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt < C_DEPTH) begin
                    w_imem_we   = 1'b1;
                    w_imem_addr = r_clr_cnt[ADDR_W-1:0];
                    w_imem_data = 32'd0;
                    w_clr_cnt   = r_clr_cnt + C_ONE;
                end else begin
                    w_clr_cnt   = r_clr_cnt;
                end
            end
            S_HDR: begin
                if (w_word_done && !w_hdr_bad) begin
                    // Header already range-checked, so it fits in ADDR_W+1 bits.
                    w_n   = w_word[ADDR_W:0];
                    w_idx = {(ADDR_W+1){1'b0}};
                end else begin
                    w_n   = r_n;
                end
            end
            S_LOAD: begin
                if (w_word_done) begin
                    w_imem_we   = 1'b1;
                    w_imem_addr = r_idx[ADDR_W-1:0];
                    w_imem_data = w_word;
                    w_idx       = w_idx_inc;
                    // Never exceeds N since LOAD is left once idx reaches N.
                    w_words     = w_idx_inc;
                end else begin
                    w_idx       = r_idx;
                end
            end
            S_DATA: begin
                if (w_word_done) begin
                    w_dmem_we   = 1'b1;
                    w_dmem_data = w_word;
                end else begin
                    w_dmem_data = r_dmem_data;
                end
            end
            default: begin
                w_imem_we = 1'b0;
                w_dmem_we = 1'b0;
            end
        endcase

        // Status flags follow the state being entered so they line up with it.
        w_ready = (w_next_state == S_HDR) || (w_next_state == S_LOAD) ||
                  (w_next_state == S_DATA);
        w_busy  = (w_next_state == S_CLEAR) || w_ready;
        w_err   = (w_next_state == S_ERR);
        // The first RUN cycle carries the dmem strobe; start follows one cycle later.
        w_start = (r_state == S_RUN) && (w_next_state == S_RUN);
    end

    // Byte counter and little-endian word assembly
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_byte_cnt <= 2'd0;
            r_asm      <= 24'd0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_asm[7:0]   <= byte_i;
                2'd1:    r_asm[15:8]  <= byte_i;
                2'd2:    r_asm[23:16] <= byte_i;
                default: r_asm        <= r_asm;
            endcase
        end else begin
            r_byte_cnt <= r_byte_cnt;
            r_asm      <= r_asm;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_clr_cnt   <= {(ADDR_W+1){1'b0}};
            r_n         <= {(ADDR_W+1){1'b0}};
            r_idx       <= {(ADDR_W+1){1'b0}};
            r_words     <= {(ADDR_W+1){1'b0}};
            r_ready     <= 1'b0;
            r_imem_we   <= 1'b0;
            r_imem_addr <= {ADDR_W{1'b0}};
            r_imem_data <= 32'd0;
            r_dmem_we   <= 1'b0;
            r_dmem_data <= 32'd0;
            r_start     <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_clr_cnt   <= w_clr_cnt;
            r_n         <= w_n;
            r_idx       <= w_idx;
            r_words     <= w_words;
            r_ready     <= w_ready;
            r_imem_we   <= w_imem_we;
            r_imem_addr <= w_imem_addr;
            r_imem_data <= w_imem_data;
            r_dmem_we   <= w_dmem_we;
            r_dmem_data <= w_dmem_data;
            r_start     <= w_start;
            r_busy      <= w_busy;
            r_err       <= w_err;
        end
    end

    assign ready_o        = r_ready;
    assign imem_we_o      = r_imem_we;
    assign imem_addr_o    = r_imem_addr;
    assign imem_data_o    = r_imem_data;
    assign dmem_we_o      = r_dmem_we;
    // The input word always lands at data address 0x00.
    assign dmem_addr_o    = 32'd0;
    assign dmem_data_o    = r_dmem_data;
    assign start_o        = r_start;
    assign busy_o         = r_busy;
    assign err_o          = r_err;
    assign words_loaded_o = r_words;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Hardware boot stage directly upstream of the pipelined CPU: fills instruction memory and the input word at data memory 0x00, then raises the CPU start line.
- Sequence: zero-fill all instruction memory, then take a little-endian byte stream with a valid/ready handshake.
- Stream layout: header word N, then N instruction words, then one data word.
- start_o drives the CPU's start_i. The memory write ports drive the instruction-memory and data-memory initialisation ports.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction-memory words.
- ADDR_W, 8, instruction word-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- byte_i  in  8  stream byte.
- valid_i  in  1  byte_i valid.
- ready_o  out  1  loader accepts a byte this cycle.
- imem_we_o  out  1  instruction-memory write strobe.
- imem_addr_o  out  ADDR_W  instruction word index.
- imem_data_o  out  32  instruction word.
- dmem_we_o  out  1  data-memory write strobe.
- dmem_addr_o  out  32  data-memory byte address.
- dmem_data_o  out  32  data word.
- start_o  out  1  CPU start.
- busy_o  out  1  high in CLEAR, HDR, LOAD and DATA.
- err_o  out  1  bad header.
- words_loaded_o  out  ADDR_W+1  instruction words written so far.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=CLEAR, all strobes 0, start_o=0, err_o=0, ready_o=0, busy_o=1.
  - imem_addr_o=0, imem_data_o=0, dmem_addr_o=0, dmem_data_o=0, words_loaded_o=0.
  - Byte counter and assembly register cleared.
- Handshake: a byte is accepted on a rising edge where valid_i && ready_o. valid_i may drop at any time; gaps cost nothing else. ready_o is registered: 1 in HDR, LOAD and DATA; 0 otherwise.
- Word assembly: bytes are assembled little-endian (first byte is [7:0]). A 2-bit byte counter wraps 3->0 on the 4th accepted byte, which completes the word.
- CLEAR:
  - Starts on the first edge after rst_i deasserts.
  - Issues imem_we_o=1, data 0, addr 0,1,...,IMEM_DEPTH-1, one per cycle (IMEM_DEPTH consecutive strobe cycles).
  - Moves to HDR on the edge after the last write; ready_o=1 from that cycle.
- HDR: the completed word is N.
  - N==0 or N>IMEM_DEPTH: go to ERR; err_o=1 and ready_o=0 on the next cycle.
  - Otherwise: latch N, idx=0, go to LOAD.
- LOAD:
  - Each completed word gives imem_we_o=1 for exactly one cycle: the cycle after the 4th byte is accepted, with addr=idx and data=word.
  - idx and words_loaded_o increment in that same cycle.
  - When idx reaches N, go to DATA.
  - A byte may be accepted in the same cycle as a write strobe (zero bubble).
- DATA: the completed word gives dmem_we_o=1 for one cycle, the cycle after the 4th byte is accepted, with dmem_addr_o=0 and dmem_data_o=word. Then go to RUN.
- RUN: start_o=1 from the cycle after the dmem_we_o pulse, held until reset. ready_o=0, busy_o=0. Bytes are ignored.
- ERR: start_o=0, ready_o=0, busy_o=0, err_o=1, held until reset. No further memory writes.
- Reset mid-operation: the partial word is discarded, counters clear, and the sequence restarts from CLEAR. start_o drops asynchronously.
- imem_we_o and dmem_we_o are never high together.
- Strobes only ever pulse in CLEAR/LOAD/DATA, never in RUN/ERR.
- words_loaded_o saturates at N.

Test Plan:
- Reset release, valid_i=0: imem_we_o high for exactly 256 consecutive cycles, addr 0..255, data 0. Then ready_o=1, busy_o=1, start_o=0.
- Stream header 3, words 0x00500093, 0x00000013, 0xFFF00113, data 5, valid every cycle:
  - imem writes at addr 0,1,2 with those words, then dmem write addr 0 data 5.
  - start_o=1 one cycle later; words_loaded_o=3.
- Same stream with valid_i toggling 1,0,0,1 and random gaps: identical write contents and order; no strobe without a completed 4th byte.
- Header N=0, and separately N=257: err_o=1 and ready_o=0 after the 4th header byte; no further writes; start_o stays 0.
- Reset asserted after 2 bytes of word 1 in LOAD: outputs return to reset values immediately. The full restart (256-cycle clear, then fresh stream) gives correct memory contents.
- In RUN, drive valid_i=1 with bytes for 20 cycles: no strobes, start_o stays 1, ready_o stays 0.
